// File: rtl/dsp_tdm_mac.sv
// Time-multiplexed (D+/-B)*A multiply-accumulate slice with per-channel
// accumulate-and-dump, optional saturation and a four-stage CE-gated pipeline.
module dsp_tdm_mac #(
  parameter int AW  = 18,
  parameter int BW  = 18,
  parameter int PW  = 48,
  parameter int NCH = 4,
  parameter int LW  = 8,
  parameter bit SAT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic [$clog2(NCH)-1:0]     in_ch,
  input  logic [1:0]                 mode,
  input  logic signed [AW-1:0]       a,
  input  logic signed [BW-1:0]       b,
  input  logic signed [BW-1:0]       d,
  input  logic [LW-1:0]              acc_len,
  output logic                       out_valid,
  output logic [$clog2(NCH)-1:0]     out_ch,
  output logic signed [PW-1:0]       p,
  output logic                       ovf
);

  localparam int CW = $clog2(NCH);
  localparam int MW = AW + BW + 1;
  localparam logic signed [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};

  logic                 v1_r, v2_r, v3_r;
  logic [CW-1:0]        ch1_r, ch2_r, ch3_r;
  logic [LW-1:0]        len1_r, len2_r, len3_r;
  logic [1:0]           mode1_r;
  logic signed [AW-1:0] a1_r, a2_r;
  logic signed [BW-1:0] b1_r, d1_r;
  logic signed [BW:0]   pre2_r;
  logic                 neg2_r;
  logic signed [PW-1:0] prod3_r;

  logic signed [PW-1:0] acc_r  [NCH];
  logic [LW-1:0]        cnt_r  [NCH];
  logic                 ovfw_r [NCH];

  logic signed [BW:0]   pre_s;
  logic signed [MW-1:0] mul_s;
  logic signed [PW-1:0] mul_ext_s, prod_s;
  logic signed [PW-1:0] acc_cur_s, res_s;
  logic signed [PW:0]   sum_s;
  logic                 ov_s, dump_s;
  logic [LW:0]          cnt_nxt_s, len_eff_s;

  // Pre-adder: operand selection widened by one bit so D+/-B never wraps
  always_comb begin
    pre_s = (BW+1)'(b1_r);
    case (mode1_r)
      2'b01:   pre_s = (BW+1)'(d1_r) + (BW+1)'(b1_r);
      2'b10:   pre_s = (BW+1)'(d1_r) - (BW+1)'(b1_r);
      default: pre_s = (BW+1)'(b1_r);
    endcase
  end

  // Multiplier with sign extension to the accumulator width and optional negate
  always_comb begin
    mul_s     = MW'(a2_r) * MW'(pre2_r);
    mul_ext_s = PW'(mul_s);
    if (neg2_r) begin
      prod_s = -mul_ext_s;
    end else begin
      prod_s = mul_ext_s;
    end
  end

  // Accumulate, overflow detect on the PW+1 sum, and dump decision
  always_comb begin
    acc_cur_s = acc_r[ch3_r];
    sum_s     = (PW+1)'(acc_cur_s) + (PW+1)'(prod3_r);
    ov_s      = sum_s[PW] ^ sum_s[PW-1];
    if (ov_s && SAT) begin
      res_s = sum_s[PW] ? P_MIN : P_MAX;
    end else begin
      res_s = sum_s[PW-1:0];
    end
    cnt_nxt_s = {1'b0, cnt_r[ch3_r]} + {{LW{1'b0}}, 1'b1};
    if (len3_r == {LW{1'b0}}) begin
      len_eff_s = {{LW{1'b0}}, 1'b1};
    end else begin
      len_eff_s = {1'b0, len3_r};
    end
    dump_s = (cnt_nxt_s >= len_eff_s);
  end

  // Pipeline stages S1..S3
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r <= 1'b0; v2_r <= 1'b0; v3_r <= 1'b0;
      ch1_r <= {CW{1'b0}}; ch2_r <= {CW{1'b0}}; ch3_r <= {CW{1'b0}};
      len1_r <= {LW{1'b0}}; len2_r <= {LW{1'b0}}; len3_r <= {LW{1'b0}};
      mode1_r <= 2'b00;
      a1_r <= {AW{1'b0}}; a2_r <= {AW{1'b0}};
      b1_r <= {BW{1'b0}}; d1_r <= {BW{1'b0}};
      pre2_r <= {(BW+1){1'b0}};
      neg2_r <= 1'b0;
      prod3_r <= {PW{1'b0}};
    end else if (ce) begin
      v1_r <= in_valid; ch1_r <= in_ch; len1_r <= acc_len;
      mode1_r <= mode; a1_r <= a; b1_r <= b; d1_r <= d;
      v2_r <= v1_r; ch2_r <= ch1_r; len2_r <= len1_r;
      a2_r <= a1_r; pre2_r <= pre_s; neg2_r <= (mode1_r == 2'b11);
      v3_r <= v2_r; ch3_r <= ch2_r; len3_r <= len2_r;
      prod3_r <= prod_s;
    end
  end

  // S4: per-channel read-modify-write and registered dump outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc_r[i]  <= {PW{1'b0}};
        cnt_r[i]  <= {LW{1'b0}};
        ovfw_r[i] <= 1'b0;
      end
      out_valid <= 1'b0;
      out_ch    <= {CW{1'b0}};
      p         <= {PW{1'b0}};
      ovf       <= 1'b0;
    end else if (ce) begin
      if (v3_r) begin
        if (dump_s) begin
          p             <= res_s;
          out_ch        <= ch3_r;
          out_valid     <= 1'b1;
          ovf           <= ovfw_r[ch3_r] | ov_s;
          acc_r[ch3_r]  <= {PW{1'b0}};
          cnt_r[ch3_r]  <= {LW{1'b0}};
          ovfw_r[ch3_r] <= 1'b0;
        end else begin
          acc_r[ch3_r]  <= res_s;
          cnt_r[ch3_r]  <= cnt_nxt_s[LW-1:0];
          ovfw_r[ch3_r] <= ovfw_r[ch3_r] | ov_s;
          out_valid     <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_tdm_mac.sv
// Directed plus randomized bench for dsp_tdm_mac: two instances (saturating and
// wrapping, PW=40) share stimulus and are checked every cycle against a model.
module tb_dsp_tdm_mac;
  localparam int AW = 18, BW = 18, PW = 40, NCH = 4, LW = 8;
  localparam longint PMAX = (longint'(1) <<< (PW-1)) - 1;
  localparam longint PMIN = -(longint'(1) <<< (PW-1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ce, in_valid;
  logic [1:0] in_ch, mode;
  logic signed [AW-1:0] a;
  logic signed [BW-1:0] b, d;
  logic [LW-1:0] acc_len;
  logic ov_s, ov_w, ovf_s, ovf_w;
  logic [1:0] ch_s, ch_w;
  logic signed [PW-1:0] p_s, p_w;

  dsp_tdm_mac #(.AW(AW), .BW(BW), .PW(PW), .NCH(NCH), .LW(LW), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ch(in_ch), .mode(mode),
    .a(a), .b(b), .d(d), .acc_len(acc_len),
    .out_valid(ov_s), .out_ch(ch_s), .p(p_s), .ovf(ovf_s));

  dsp_tdm_mac #(.AW(AW), .BW(BW), .PW(PW), .NCH(NCH), .LW(LW), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ch(in_ch), .mode(mode),
    .a(a), .b(b), .d(d), .acc_len(acc_len),
    .out_valid(ov_w), .out_ch(ch_w), .p(p_w), .ovf(ovf_w));

  // Model: index 0 = saturating instance, 1 = wrapping instance
  longint m_acc [2][NCH];
  bit     m_ovf [2][NCH];
  int     m_cnt [NCH];
  bit     q_v [8];
  int     q_ch [8];
  longint q_p [2][8];
  bit     q_o [2][8];
  bit     e_v;
  int     e_ch;
  longint e_p [2];
  bit     e_o [2];
  int     ecnt;
  int     n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[s][c] = 0; m_ovf[s][c] = 1'b0;
      end
      e_p[s] = 0; e_o[s] = 1'b0;
    end
    for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
    for (int k = 0; k < 8; k++) q_v[k] = 1'b0;
    e_v = 1'b0; e_ch = 0; ecnt = 0;
  endtask

  // Applies the architectural rules to the sample on the inputs; result due 3 enabled edges later
  task automatic model_sample();
    longint pre, prod, sum, r;
    bit o, dump;
    int len_eff, c, slot;
    c = int'(in_ch);
    slot = (ecnt + 3) % 8;
    case (mode)
      2'd1:    pre = longint'(d) + longint'(b);
      2'd2:    pre = longint'(d) - longint'(b);
      default: pre = longint'(b);
    endcase
    prod = longint'(a) * pre;
    if (mode == 2'd3) prod = -prod;
    len_eff = (acc_len == 8'd0) ? 1 : int'(acc_len);
    dump = (m_cnt[c] + 1 >= len_eff);
    for (int s = 0; s < 2; s++) begin
      sum = m_acc[s][c] + prod;
      o = (sum > PMAX) || (sum < PMIN);
      if (!o) r = sum;
      else if (s == 0) r = (sum > PMAX) ? PMAX : PMIN;
      else r = (sum <<< (64-PW)) >>> (64-PW);
      if (dump) begin
        q_p[s][slot] = r; q_o[s][slot] = m_ovf[s][c] | o;
        m_acc[s][c] = 0; m_ovf[s][c] = 1'b0;
      end else begin
        m_acc[s][c] = r; m_ovf[s][c] = m_ovf[s][c] | o;
      end
    end
    if (dump) begin
      q_v[slot] = 1'b1; q_ch[slot] = c; m_cnt[c] = 0;
    end else begin
      m_cnt[c] = m_cnt[c] + 1;
    end
  endtask

  task automatic step(input bit iv, input int ch, input int md, input longint av, input longint bv,
                      input longint dv, input int ln, input bit cev = 1'b1, input bit rstv = 1'b0);
    int k;
    in_valid = iv; in_ch = ch[1:0]; mode = md[1:0];
    a = av[AW-1:0]; b = bv[BW-1:0]; d = dv[BW-1:0]; acc_len = ln[LW-1:0];
    ce = cev; rst = rstv;
    @(posedge clk);
    if (rstv) begin
      model_reset();
    end else if (cev) begin
      ecnt++;
      k = ecnt % 8;
      e_v = q_v[k];
      if (q_v[k]) begin
        e_ch = q_ch[k];
        for (int s = 0; s < 2; s++) begin e_p[s] = q_p[s][k]; e_o[s] = q_o[s][k]; end
      end
      q_v[k] = 1'b0;
      if (iv) model_sample();
    end
    #1;
    chk("out_valid_sat", ov_s, e_v);
    chk("out_valid_wrap", ov_w, e_v);
    chk("out_ch_sat", ch_s, e_ch);
    chk("out_ch_wrap", ch_w, e_ch);
    chk("p_sat", p_s, e_p[0]);
    chk("p_wrap", p_w, e_p[1]);
    chk("ovf_sat", ovf_s, e_o[0]);
    chk("ovf_wrap", ovf_w, e_o[1]);
  endtask

  task automatic idle(input int n, input bit cev = 1'b1);
    repeat (n) step(1'b0, 0, 0, 0, 0, 0, 1, cev, 1'b0);
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    int i;
    i = 0;
    while (ov_s !== 1'b1 && i < budget) begin
      idle(1);
      i++;
    end
    n_cmp++;
    assert (ov_s === 1'b1) else begin
      n_bad++;
      $error("FAIL %s: observed no strobe expected strobe within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    model_reset();
    // Reset with valid random samples; second cycle also has CE low
    step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), longint'($urandom_range(0, 262143)) - 131072,
         longint'($urandom_range(0, 262143)) - 131072, 5, 1, 1'b1, 1'b1);
    step(1'b1, 1, 1, 77, -33, 12, 1, 1'b0, 1'b1);
    chk("reset_p", p_s, 0);
    chk("reset_out_valid", ov_s, 0);
    chk("reset_ovf", ovf_s, 0);
    idle(4);

    // Single channel pre-add
    repeat (3) step(1'b1, 0, 1, 5, 6, 8, 3);
    wait_strobe("preadd_strobe", 6);
    chk("preadd_p", p_s, 210);
    chk("preadd_ch", ch_s, 0);
    chk("preadd_ovf", ovf_s, 0);
    idle(2);

    // Interleaved channels, add then subtract mode
    for (int m = 0; m < 2; m++) begin
      repeat (2) begin
        step(1'b1, 0, (m == 0) ? 0 : 3, 2, 3, 0, 2);
        step(1'b1, 1, (m == 0) ? 0 : 3, 4, -1, 0, 2);
      end
      wait_strobe("ilv_strobe0", 6);
      chk("ilv_p0", p_s, (m == 0) ? 12 : -12);
      chk("ilv_ch0", ch_s, 0);
      idle(1);
      chk("ilv_valid1", ov_s, 1);
      chk("ilv_p1", p_s, (m == 0) ? -8 : 8);
      chk("ilv_ch1", ch_s, 1);
      idle(2);
    end

    // Overflow window then a clean window
    repeat (64) step(1'b1, 2, 0, -131072, -131072, 0, 64);
    wait_strobe("ovf_strobe", 6);
    chk("ovf_p_sat", p_s, PMAX);
    chk("ovf_flag_sat", ovf_s, 1);
    chk("ovf_p_wrap", p_w, 0);
    chk("ovf_flag_wrap", ovf_w, 1);
    repeat (64) step(1'b1, 2, 0, 1, 1, 0, 64);
    wait_strobe("clean_strobe", 6);
    chk("clean_p", p_s, 64);
    chk("clean_ovf_sat", ovf_s, 0);
    chk("clean_ovf_wrap", ovf_w, 0);
    idle(2);

    // CE stall mid-window and across the strobe
    step(1'b1, 0, 1, 5, 6, 8, 3);
    step(1'b1, 0, 1, 5, 6, 8, 3);
    idle(3, 1'b0);
    step(1'b1, 0, 1, 5, 6, 8, 3);
    wait_strobe("stall_strobe", 6);
    chk("stall_p", p_s, 210);
    idle(2, 1'b0);
    chk("stall_hold_valid", ov_s, 1);
    chk("stall_hold_p", p_s, 210);
    idle(2);

    // Mid-window reset, then zero ACC_LEN
    repeat (2) step(1'b1, 0, 0, 10, 10, 0, 3);
    step(1'b0, 0, 0, 0, 0, 0, 3, 1'b1, 1'b1);
    repeat (3) step(1'b1, 0, 0, 1, 1, 0, 3);
    wait_strobe("midrst_strobe", 6);
    chk("midrst_p", p_s, 3);
    repeat (3) step(1'b1, 0, 0, 7, 2, 0, 0);
    wait_strobe("zlen_strobe", 6);
    chk("zlen_p0", p_s, 14);
    idle(1);
    chk("zlen_valid1", ov_s, 1);
    chk("zlen_p1", p_s, 14);
    idle(1);
    chk("zlen_valid2", ov_s, 1);
    idle(2);

    // Randomized traffic with stalls and occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           longint'($urandom_range(0, 262143)) - 131072, longint'($urandom_range(0, 262143)) - 131072,
           longint'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 5)),
           ($urandom % 5) != 0, ($urandom % 97) == 0);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
